// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input sync, mid-bit sampling from a clock-derived
// baud divider, ASCII-offset removal, one-cycle valid / frame-error strobes.
module uart_rx #(
  parameter int BAUD   = 115200,
  parameter int F      = 50000000,
  parameter int OFFSET = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  // DIV is rounded to the nearest whole cycle and must be at least 4.
  localparam int DIV  = (F + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [7:0]    OFF8    = 8'(OFFSET);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state_q;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q;

  logic            rs;
  logic            tick;
  logic [7:0]      shift_d;
  logic [7:0]      data_d;
  logic [CW-1:0]   cnt_inc;

  always_comb begin
    rs      = sync_q[1];
    tick    = (cnt_q == DIV_M1);
    cnt_inc = cnt_q + 1'b1;
    // LSB arrives first, so shifting in at the MSB leaves the byte in natural order.
    shift_d = {rs, shift_q[7:1]};
    data_d  = shift_q - OFF8;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rs) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (rs) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              idx_q   <= 3'd0;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        DATA: begin
          if (tick) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        STOP: begin
          if (tick) begin
            cnt_q <= '0;
            if (rs) begin
              data_q  <= data_d;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        BREAK: begin
          // A held-low line must return high before another start is accepted.
          cnt_q <= '0;
          if (rs) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (OFFSET=48 and OFFSET=0) share one rx line;
// stimulus queues expected strobes, a negedge monitor pops and compares them.
module tb_uart_rx;

  localparam int F    = 160;
  localparam int BAUD = 10;
  localparam int DIV  = 16;
  localparam int LAT  = 155; // rx drive cycle -> strobe cycle: 2 sync + HALF + 9*DIV + 1

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, fe0, fe1, busy0, busy1;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last0 = 8'd0;
  logic [7:0] last1 = 8'd0;

  uart_rx #(.BAUD(BAUD), .F(F), .OFFSET(48)) dut0 (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data0), .valid(valid0), .frame_err(fe0), .busy(busy0)
  );

  uart_rx #(.BAUD(BAUD), .F(F), .OFFSET(0)) dut1 (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data1), .valid(valid1), .frame_err(fe1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_out(input int which, input logic v, input logic fe, input logic [7:0] d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (v && fe) begin
      checks++;
      errors++;
      $display("FAIL dut%0d both_strobes: valid=%b frame_err=%b required not both high", which, v, fe);
    end
    if (v || fe) begin
      checks++;
      if (which == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (which == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        errors++;
        $display("FAIL dut%0d unexpected_strobe: valid=%b frame_err=%b data=%h at cyc %0d, none required", which, v, fe, d, cyc);
      end else if (fe != e.err || d !== e.data || cyc != e.cyc) begin
        errors++;
        $display("FAIL dut%0d strobe: got err=%b data=%h cyc=%0d, required err=%b data=%h cyc=%0d",
                 which, fe, d, cyc, e.err, e.data, e.cyc);
      end else begin
        $display("dut%0d %s data=%h cyc=%0d ok", which, fe ? "frame_err" : "valid", d, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check_out(0, valid0, fe0, data0);
      check_out(1, valid1, fe1, data1);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; e0/e1 are hand-computed outputs for OFFSET=48 / OFFSET=0.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input logic [7:0] e0, input logic [7:0] e1, input int low_tail);
    exp_t x;
    x.cyc = cyc + LAT;
    x.err = !stop_ok;
    if (stop_ok) begin
      last0 = e0;
      last1 = e1;
    end
    x.data = last0;
    q0.push_back(x);
    x.data = last1;
    q1.push_back(x);
    rx = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(DIV);
    end
    rx = stop_ok;
    wait_cyc(DIV + (stop_ok ? 0 : low_tail));
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 600) begin
      wait_cyc(1);
      n++;
    end
    wait_cyc(2);
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL %s drain: pending q0=%0d q1=%0d, required 0 0", name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (data0 !== 8'd0 || valid0 !== 1'b0 || fe0 !== 1'b0 || busy0 !== 1'b0 ||
        data1 !== 8'd0 || valid1 !== 1'b0 || fe1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL %s: dut0 d=%h v=%b fe=%b busy=%b dut1 d=%h v=%b fe=%b busy=%b, required all 0",
               name, data0, valid0, fe0, busy0, data1, valid1, fe1, busy1);
    end else begin
      $display("%s: all outputs 0 ok", name);
    end
  endtask

  initial begin
    int bc;

    // Reset state
    #2;
    check_idle_outputs("reset_async");
    wait_cyc(3);
    check_idle_outputs("reset_held");
    rst = 1'b1;
    wait_cyc(5);
    check_idle_outputs("after_release");

    // Single frame '5'
    send_frame(8'h35, 1'b1, 8'h05, 8'h35, 0);
    drain("frame_35");
    wait_cyc(5);

    // Back-to-back frames, no idle gap
    send_frame(8'hA5, 1'b1, 8'h75, 8'hA5, 0);
    send_frame(8'h3C, 1'b1, 8'h0C, 8'h3C, 0);
    drain("b2b");
    wait_cyc(5);

    // Start glitch of 4 cycles
    rx = 1'b0;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx = 1'b1;
      if (busy0) bc++;
      wait_cyc(1);
    end
    checks++;
    if (bc < 1 || bc > 9) begin
      errors++;
      $display("FAIL glitch_busy: busy cycles %0d, required 1..9", bc);
    end else begin
      $display("glitch_busy: busy cycles %0d ok", bc);
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: busy0=%b busy1=%b, required 0 0", busy0, busy1);
    end
    drain("glitch");

    // Framing error with held-low line, then recovery
    send_frame(8'h41, 1'b0, 8'h00, 8'h00, 40);
    wait_cyc(10);
    send_frame(8'h31, 1'b1, 8'h01, 8'h31, 0);
    drain("frame_err");
    wait_cyc(5);

    // Reset during bit 3
    rx = 1'b0;
    wait_cyc(DIV);
    rx = 1'b1; wait_cyc(DIV);
    rx = 1'b0; wait_cyc(DIV);
    rx = 1'b1; wait_cyc(DIV);
    rx = 1'b0; wait_cyc(DIV / 2);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    rx = 1'b1;
    wait_cyc(3);
    check_idle_outputs("midframe_reset_held");
    rst = 1'b1;
    last0 = 8'd0;
    last1 = 8'd0;
    wait_cyc(20);
    checks++;
    if (busy0 !== 1'b0 || valid0 !== 1'b0 || fe0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b valid=%b fe=%b, required 0 0 0", busy0, valid0, fe0);
    end
    send_frame(8'h32, 1'b1, 8'h02, 8'h32, 0);
    drain("after_reset");
    wait_cyc(5);

    // Offset wrap-around
    send_frame(8'h2F, 1'b1, 8'hFF, 8'h2F, 0);
    drain("wrap");
    wait_cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
